// File: rtl/reg_bcd_converter.sv
// Iterative binary-to-BCD converter (double-dabble, one bit per clock) feeding the
// seven-segment digit driver; results hold steady between conversions.
module reg_bcd_converter #(
   parameter int DIGITS = 8  // displayed digits, 1..10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            in_value,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DIGITS-1:0][3:0] digits,
   output logic [DIGITS-1:0]      en,
   output logic                   ovf,
   output logic                   out_valid
);

   // Handshake: a value is taken on any rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE, and in_valid at any other time is ignored.
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state;
   logic [31:0] bin;
   logic [39:0] scratch;       // ten BCD digits, enough for any 32-bit value
   logic [4:0]  cnt;
   logic [39:0] adjusted;
   logic [3:0]  nib;
   logic        high_nz;
   logic        seen;
   logic [DIGITS-1:0] en_mask;

   assign in_ready = (state == IDLE);

   always_comb begin
      adjusted = '0;
      nib      = '0;
      high_nz  = 1'b0;
      seen     = 1'b0;
      en_mask  = '0;
      // add-3 is nibble-local; a nibble >= 5 never carries into its neighbour
      for (int i = 0; i < 10; i++) begin
         nib = scratch[4*i +: 4];
         adjusted[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
      for (int i = DIGITS; i < 10; i++) begin
         high_nz = high_nz | (scratch[4*i +: 4] != 4'd0);
      end
      // light every digit from the most significant nonzero one downwards
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen = seen | (scratch[4*i +: 4] != 4'd0);
         en_mask[i] = seen;
      end
      en_mask[0] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bin       <= '0;
         scratch   <= '0;
         cnt       <= '0;
         digits    <= '0;
         en        <= DIGITS'(1);
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bin     <= in_value;
                  scratch <= '0;
                  cnt     <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               {scratch, bin} <= {adjusted, bin} << 1;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= DONE;
            end
            DONE: begin
               if (high_nz) begin
                  ovf    <= 1'b1;
                  digits <= {DIGITS{4'd9}};
                  en     <= '1;
               end else begin
                  ovf    <= 1'b0;
                  digits <= scratch[4*DIGITS-1:0];
                  en     <= en_mask;
               end
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
